irda_sir_demod_param: RTL and testbench
=======================================

// Module: irda_sir_demod_param
// PURPOSE
//  Parametrised IrDA SIR receive demodulator: converts RZI IR pulses (one short pulse per '0' bit) to NRZ UART rx.
//  Sits between the IR transceiver pin and the UART receiver; rx_enable gates echo during local transmit.
//  Adds input sync, glitch filter, bit-clock realignment with tolerance, idle timeout and error strobes.
// PARAMETERS
//  BIT_CYCLES     5208  clocks per UART bit (50 MHz / 9600); >= 8
//  TOL            260   realignment tolerance in clocks (~5%); < BIT_CYCLES/4
//  MIN_PULSE      32    consecutive active clocks to accept a pulse; >= 1, < MAX_PULSE
//  MAX_PULSE      1200  active clocks beyond which err_long_pulse fires
//  IDLE_BITS      10    consecutive empty bit windows before returning to IDLE; >= 1
//  SYNC_STAGES    2     input synchroniser depth; >= 2
//  IR_ACTIVE_LOW  1     1: rx_ir_data pulse is low; 0: pulse is high
// PORTS
//  clock           in   1  system clock
//  reset_n         in   1  asynchronous, active-low reset
//  rx_enable       in   1  1 = receive; 0 = suppress (local transmit in progress)
//  rx_ir_data      in   1  raw IR receiver output, asynchronous
//  uart_rx_data    out  1  NRZ data to UART receiver, idle high
//  rx_active       out  1  1 while state != IDLE
//  pulse_strobe    out  1  one-cycle strobe per accepted pulse
//  err_early_pulse out  1  one-cycle strobe: pulse accepted too early inside a ZERO window
//  err_long_pulse  out  1  one-cycle strobe: active level held > MAX_PULSE clocks
// BEHAVIOUR
//  Reset (async assert, sync release): uart_rx_data=1, rx_active=0, all strobes 0, state IDLE, counters 0, sync chain inactive.
//  Input: SYNC_STAGES flops, then polarity applied -> act (1 = pulse level).
//  Filter: run counter increments while act=1, clears when act=0, saturates at MAX_PULSE+1.
//   pulse event (pulse_strobe) on cycle run reaches MIN_PULSE; max one event per pulse.
//   err_long_pulse on cycle run reaches MAX_PULSE+1; once per pulse.
//  Latency: raw edge -> pulse_strobe = SYNC_STAGES+MIN_PULSE clocks; uart_rx_data falls the cycle after pulse_strobe.
//  Bit counter cnt width = $clog2(BIT_CYCLES+TOL); idle_cnt width = $clog2(IDLE_BITS+1).
//  FSM (registered outputs):
//   IDLE : out=1. pulse event -> ZERO, cnt=0.
//   ZERO : out=0, cnt++. event with cnt >= BIT_CYCLES-TOL -> stay ZERO, cnt=0 (next '0' bit, realigned).
//          event with cnt < BIT_CYCLES-TOL -> ignored, err_early_pulse.
//          cnt == BIT_CYCLES-1+TOL, no event -> ONE, cnt=TOL, idle_cnt=0.
//   ONE  : out=1, cnt++. event at any cnt -> ZERO, cnt=0, idle_cnt=0.
//          cnt == BIT_CYCLES-1 -> cnt=0, idle_cnt++; idle_cnt reaching IDLE_BITS -> IDLE.
//  Simultaneous event and window end: event wins (ZERO, cnt=0).
//  rx_enable=0: next cycle state IDLE, out=1, cnt/idle_cnt=0, strobes/errors masked; filter keeps running
//   so a pulse already active at re-enable is not accepted until it ends and a new one starts.
//  Mid-pulse async reset: all state cleared immediately; no strobe on release even if pin still active.
// STRUCTURE
//  Package irda_pkg: state enum {IDLE, ZERO, ONE} (2-bit), shared polarity/timing localparam helpers.
//  Sub-module irda_pulse_filter: synchroniser + polarity + run counter -> pulse event, err_long_pulse.
//  Top: FSM, bit counter, idle counter, output registers.
// TESTING (sim params BIT_CYCLES=100, TOL=5, MIN_PULSE=4, MAX_PULSE=30, IDLE_BITS=2, SYNC_STAGES=2)
//  Byte 0x55 as 10 RZI bits, pulse 20 clks at 100-clk pitch -> uart_rx_data reproduces 0,1,0,1,0,1,0,1,0,1 NRZ, 100-clk bits, first fall 7 clks after pulse edge.
//  3-clk glitch then 20-clk pulse -> no strobe for glitch; one pulse_strobe; uart_rx_data low.
//  Two pulses 98 clks apart then 103 apart (drift within TOL) -> continuous low, no err_early_pulse.
//  Second pulse 40 clks after first -> err_early_pulse=1 one cycle, bit window unchanged.
//  Pulse held 50 clks -> err_long_pulse one cycle at run=31; single pulse_strobe.
//  rx_enable dropped in ZERO -> uart_rx_data=1, rx_active=0 next cycle; pulses ignored while 0; two empty windows after a '1' -> IDLE.

Source files
------------

// File: rtl/irda_pkg.sv
// Shared types and helpers for the IrDA SIR receive demodulator.
// Holds the FSM state encoding plus pin-polarity and counter-width helpers.
package irda_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ONE  = 2'd2
  } irda_state_t;

  // Raw pin level that means "no pulse present".
  function automatic logic ir_idle_level(input bit active_low);
    return active_low;
  endfunction

  function automatic logic ir_act(input logic raw, input bit active_low);
    return active_low ? ~raw : raw;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irda_pulse_filter.sv
// Synchronises the raw IR pin, applies polarity and measures pulse length.
// Emits one accept event per pulse and one long-pulse error per pulse.
module irda_pulse_filter
  import irda_pkg::*;
#(
  parameter int MIN_PULSE     = 32,
  parameter int MAX_PULSE     = 1200,
  parameter int SYNC_STAGES   = 2,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic rx_ir_data,
  output logic pulse_ev,
  output logic err_long
);

  localparam int            RW         = ctr_width(MAX_PULSE + 2);
  localparam logic [RW-1:0] RUN_ACCEPT = RW'(MIN_PULSE - 1);
  localparam logic [RW-1:0] RUN_LONG   = RW'(MAX_PULSE);
  localparam logic [RW-1:0] RUN_SAT    = RW'(MAX_PULSE + 1);
  localparam logic          IDLE_LVL   = ir_idle_level(IR_ACTIVE_LOW);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic [RW-1:0]          run_q;
  logic                   armed_q;
  logic                   act;

  assign act = ir_act(sync_q[SYNC_STAGES-1], IR_ACTIVE_LOW);

  // armed_q stays low after reset until the settled pin has been seen idle,
  // so a pulse already in progress at reset release is never accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {SYNC_STAGES{IDLE_LVL}};
      settle_q <= '0;
      run_q    <= '0;
      armed_q  <= 1'b0;
      pulse_ev <= 1'b0;
      err_long <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_ir_data};
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settle_q[SYNC_STAGES-1] && !act) armed_q <= 1'b1;
      if (!act)                 run_q <= '0;
      else if (run_q != RUN_SAT) run_q <= run_q + 1'b1;
      pulse_ev <= enable && armed_q && act && (run_q == RUN_ACCEPT);
      err_long <= enable && armed_q && act && (run_q == RUN_LONG);
    end
  end

endmodule

// File: rtl/irda_sir_demod_param.sv
// IrDA SIR receive demodulator: RZI pulses in, NRZ UART rx out.
// state | meaning
// IDLE  | no traffic, line high, waiting for a first pulse
// ZERO  | inside a '0' bit window (line low), late pulses realign the window
// ONE   | inside '1' bit windows (line high), counting empty windows to idle
module irda_sir_demod_param
  import irda_pkg::*;
#(
  parameter int BIT_CYCLES    = 5208,
  parameter int TOL           = 260,
  parameter int MIN_PULSE     = 32,
  parameter int MAX_PULSE     = 1200,
  parameter int IDLE_BITS     = 10,
  parameter int SYNC_STAGES   = 2,
  parameter bit IR_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rx_enable,
  input  logic rx_ir_data,
  output logic uart_rx_data,
  output logic rx_active,
  output logic pulse_strobe,
  output logic err_early_pulse,
  output logic err_long_pulse
);

  localparam int            CW            = ctr_width(BIT_CYCLES + TOL);
  localparam int            IW            = ctr_width(IDLE_BITS + 1);
  localparam logic [CW-1:0] CNT_REALIGN   = CW'(BIT_CYCLES - TOL);
  localparam logic [CW-1:0] CNT_ZERO_END  = CW'(BIT_CYCLES - 1 + TOL);
  localparam logic [CW-1:0] CNT_ONE_END   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE_START = CW'(TOL);
  localparam logic [IW-1:0] IDLE_LAST     = IW'(IDLE_BITS - 1);

  irda_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idle_cnt_q;
  logic          pulse_ev;

  irda_pulse_filter #(
    .MIN_PULSE    (MIN_PULSE),
    .MAX_PULSE    (MAX_PULSE),
    .SYNC_STAGES  (SYNC_STAGES),
    .IR_ACTIVE_LOW(IR_ACTIVE_LOW)
  ) u_filter (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (rx_enable),
    .rx_ir_data(rx_ir_data),
    .pulse_ev  (pulse_ev),
    .err_long  (err_long_pulse)
  );

  assign pulse_strobe = pulse_ev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idle_cnt_q      <= '0;
      uart_rx_data    <= 1'b1;
      rx_active       <= 1'b0;
      err_early_pulse <= 1'b0;
    end else if (!rx_enable) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idle_cnt_q      <= '0;
      uart_rx_data    <= 1'b1;
      rx_active       <= 1'b0;
      err_early_pulse <= 1'b0;
    end else begin
      err_early_pulse <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pulse_ev) begin
            state_q      <= ZERO;
            cnt_q        <= '0;
            idle_cnt_q   <= '0;
            uart_rx_data <= 1'b0;
            rx_active    <= 1'b1;
          end
        end
        ZERO: begin
          // The window runs TOL past the nominal bit so a slow sender can
          // still realign it; the following ONE window starts TOL in to match.
          if (pulse_ev && cnt_q >= CNT_REALIGN) begin
            cnt_q <= '0;
          end else if (pulse_ev) begin
            err_early_pulse <= 1'b1;
            cnt_q           <= cnt_q + 1'b1;
          end else if (cnt_q == CNT_ZERO_END) begin
            state_q      <= ONE;
            cnt_q        <= CNT_ONE_START;
            idle_cnt_q   <= '0;
            uart_rx_data <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ONE: begin
          if (pulse_ev) begin
            state_q      <= ZERO;
            cnt_q        <= '0;
            idle_cnt_q   <= '0;
            uart_rx_data <= 1'b0;
          end else if (cnt_q == CNT_ONE_END) begin
            cnt_q <= '0;
            if (idle_cnt_q == IDLE_LAST) begin
              state_q    <= IDLE;
              idle_cnt_q <= '0;
              rx_active  <= 1'b0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          idle_cnt_q   <= '0;
          uart_rx_data <= 1'b1;
          rx_active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irda_sir_demod_param.sv
// Scoreboard bench: a timeline of IR pulses is planned, an event-level model
// predicts every output event time into queues, and a monitor pops and compares.
module tb_irda_sir_demod_param;

  localparam int BC    = 100;
  localparam int TOL   = 5;
  localparam int MINP  = 4;
  localparam int MAXP  = 30;
  localparam int IDLEB = 2;
  localparam int SYNC  = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic rx_enable = 1'b1;
  logic rx_ir_data = 1'b1;
  logic uart_rx_data, rx_active, pulse_strobe, err_early_pulse, err_long_pulse;

  irda_sir_demod_param #(
    .BIT_CYCLES(BC), .TOL(TOL), .MIN_PULSE(MINP), .MAX_PULSE(MAXP),
    .IDLE_BITS(IDLEB), .SYNC_STAGES(SYNC), .IR_ACTIVE_LOW(1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx_enable      (rx_enable),
    .rx_ir_data     (rx_ir_data),
    .uart_rx_data   (uart_rx_data),
    .rx_active      (rx_active),
    .pulse_strobe   (pulse_strobe),
    .err_early_pulse(err_early_pulse),
    .err_long_pulse (err_long_pulse)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected event times; uart/act entries are encoded as time*2 + new level.
  int q_stb[$], q_early[$], q_long[$], q_uart[$], q_act[$];

  int p_start[$], p_len[$];
  int dis_d = -1, dis_r = -1;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit en_edge(input int k);
    return !(k >= dis_d && k < dis_r);
  endfunction

  function automatic bit pin_active(input int c);
    foreach (p_start[i])
      if (c >= p_start[i] && c < p_start[i] + p_len[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: receiver mode 0 = idle, 1 = inside a '0' bit, 2 = inside '1' bits.
  int m_mode, m_z, m_o;

  task automatic model_settle(input int t);
    int idle_t;
    if (m_mode == 1 && m_z + BC + TOL < t) begin
      m_o = m_z + BC + TOL;
      m_mode = 2;
      q_uart.push_back(m_o * 2 + 1);
    end
    idle_t = m_o + (BC - TOL) + (IDLEB - 1) * BC;
    if (m_mode == 2 && idle_t < t) begin
      m_mode = 0;
      q_act.push_back(idle_t * 2);
    end
  endtask

  task automatic model_disable();
    model_settle(dis_d);
    if (m_mode != 0) q_act.push_back(dis_d * 2);
    if (m_mode == 1) q_uart.push_back(dis_d * 2 + 1);
    m_mode = 0;
  endtask

  task automatic model_event(input int p);
    model_settle(p);
    if (m_mode == 0) begin
      m_mode = 1; m_z = p;
      q_uart.push_back(p * 2);
      q_act.push_back(p * 2 + 1);
    end else if (m_mode == 1) begin
      if (p - m_z - 1 >= BC - TOL) m_z = p;
      else q_early.push_back(p);
    end else begin
      m_mode = 1; m_z = p;
      q_uart.push_back(p * 2);
    end
  endtask

  task automatic model_build();
    bit dis_done;
    m_mode = 0; m_z = 0; m_o = 0;
    dis_done = (dis_d < 0);
    foreach (p_start[i]) begin
      int s;
      s = p_start[i] + SYNC + MINP;
      if (!dis_done && dis_d <= s + 1) begin
        model_disable();
        dis_done = 1'b1;
      end
      if (p_len[i] >= MAXP + 1 && en_edge(p_start[i] + SYNC + MAXP + 1))
        q_long.push_back(p_start[i] + SYNC + MAXP + 1);
      if (p_len[i] >= MINP && en_edge(s)) begin
        q_stb.push_back(s);
        if (en_edge(s + 1)) model_event(s + 1);
      end
    end
    if (!dis_done) model_disable();
    model_settle(1 << 30);
  endtask

  task automatic add_pulse(input int s, input int l);
    p_start.push_back(s);
    p_len.push_back(l);
  endtask

  task automatic drive_until(input int t_end);
    while (cyc < t_end) begin
      @(negedge clock);
      rx_ir_data = pin_active(cyc) ? 1'b0 : 1'b1;
      rx_enable  = en_edge(cyc + 1);
    end
  endtask

  task automatic observe(input int kind, input string name, input int got);
    int exp;
    exp = -1;
    case (kind)
      0: if (q_stb.size() > 0)   exp = q_stb.pop_front();
      1: if (q_early.size() > 0) exp = q_early.pop_front();
      2: if (q_long.size() > 0)  exp = q_long.pop_front();
      3: if (q_uart.size() > 0)  exp = q_uart.pop_front();
      default: if (q_act.size() > 0) exp = q_act.pop_front();
    endcase
    check(name, got, exp);
  endtask

  logic prev_uart = 1'b1;
  logic prev_act  = 1'b0;
  always @(negedge clock) begin
    if (pulse_strobe !== 1'b0)    observe(0, "pulse_strobe", cyc);
    if (err_early_pulse !== 1'b0) observe(1, "err_early_pulse", cyc);
    if (err_long_pulse !== 1'b0)  observe(2, "err_long_pulse", cyc);
    if (uart_rx_data !== prev_uart) begin
      observe(3, "uart_edge(t*2+lvl)", cyc * 2 + int'(uart_rx_data));
      prev_uart = uart_rx_data;
    end
    if (rx_active !== prev_act) begin
      observe(4, "rx_active_edge(t*2+lvl)", cyc * 2 + int'(rx_active));
      prev_act = rx_active;
    end
  end

  initial begin
    int t, pitch, r, st, ln, bitv, t_end, rr;
    logic [7:0] byte_v;

    // Directed timeline: 0x55 frame, glitch, drift, early, long, enable drop.
    for (int i = 0; i < 10; i += 2) add_pulse(30 + i * 100, 20);
    add_pulse(1300, 3);   add_pulse(1310, 20);
    add_pulse(1800, 20);  add_pulse(1898, 20); add_pulse(2001, 20);
    add_pulse(2500, 20);  add_pulse(2540, 20);
    add_pulse(3000, 50);
    add_pulse(3500, 20);  add_pulse(3600, 20); add_pulse(3850, 20);
    dis_d = 3550; dis_r = 3800;

    // Random frames with pitch drift, jitter, glitches, long and stray pulses.
    t = 4400;
    repeat (12) begin
      byte_v = 8'($urandom_range(0, 255));
      pitch  = 97 + int'($urandom_range(0, 6));
      for (int i = 0; i < 10; i++) begin
        bitv = (i == 0) ? 0 : (i == 9) ? 1 : int'(byte_v[i-1]);
        if (bitv == 0) begin
          st = t + i * pitch + int'($urandom_range(0, 4)) - 2;
          r  = int'($urandom_range(0, 9));
          if (r == 0)      ln = int'($urandom_range(1, 3));
          else if (r == 1) ln = int'($urandom_range(31, 45));
          else             ln = int'($urandom_range(5, 25));
          add_pulse(st, ln);
          if (r == 2) add_pulse(st + int'($urandom_range(35, 60)), 10);
        end
      end
      t += 10 * pitch + int'($urandom_range(100, 900));
    end
    t_end = t + 1000;
    model_build();

    // Reset state.
    repeat (5) @(negedge clock);
    check("rst_uart_rx_data", int'(uart_rx_data), 1);
    check("rst_rx_active", int'(rx_active), 0);
    check("rst_pulse_strobe", int'(pulse_strobe), 0);
    check("rst_err_early", int'(err_early_pulse), 0);
    check("rst_err_long", int'(err_long_pulse), 0);
    while (cyc < 8) @(negedge clock);
    reset_n = 1'b1;

    drive_until(t_end);

    // Mid-pulse reset: pin still active at release must not produce a strobe.
    p_start.delete(); p_len.delete();
    dis_d = -1; dis_r = -1;
    rr = cyc + 20;
    add_pulse(rr + 100, 20);
    model_build();
    add_pulse(rr, 30);
    drive_until(rr + 3);
    reset_n = 1'b0;
    #1;
    check("midrst_uart_rx_data", int'(uart_rx_data), 1);
    check("midrst_rx_active", int'(rx_active), 0);
    drive_until(rr + 6);
    reset_n = 1'b1;
    drive_until(rr + 600);

    check("left_pulse_strobe", q_stb.size(), 0);
    check("left_err_early", q_early.size(), 0);
    check("left_err_long", q_long.size(), 0);
    check("left_uart_edges", q_uart.size(), 0);
    check("left_rx_active_edges", q_act.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
